watch_sequencer: RTL and testbench

WATCH_SEQUENCER -- requirements
Module: watch_sequencer

---
 rtl/watch_pkg.sv | 18 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/watch_sequencer.sv | 141 ++++++++++++++
 tb/tb_watch_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and sizing helpers for the stopwatch sequencer.
// The optional lap/display-hold feature is enabled with WATCH_LAP_EN.
package watch_pkg;

    typedef enum logic [1:0] {
        StClr    = 2'd0,
        StPaused = 2'd1,
        StRun    = 2'd2,
        StAdj    = 2'd3
    } state_e;

    localparam int unsigned DebCyclesDefault = 500000;

    function automatic int unsigned deb_cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-level counter and a
// one-cycle press pulse on each accepted 0->1 change. Releases make no pulse.
module btn_debounce
    import watch_pkg::*;
#(
    parameter int unsigned DebCycles = DebCyclesDefault,
    parameter int unsigned CntW      = deb_cnt_width(DebCycles)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // The level flips on the DebCycles-th consecutive mismatching cycle;
    // a single matching cycle restarts the count from zero.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntW'(DebCycles - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= level_d & ~level_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/watch_sequencer.sv
// Stopwatch control sequencer: CLR/PAUSED/RUN/ADJ FSM with registered pulses.
// Define WATCH_LAP_EN to build the lap button and display-hold toggle.
module watch_sequencer
    import watch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DebCyclesDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic pause_btn,
    input  logic adj,
    input  logic sel,
    input  logic tick_1hz,
    input  logic tick_2hz,
    input  logic lap_btn,
    output logic cnt_clr,
    output logic count_en,
    output logic adj_step,
    output logic adj_field,
    output logic running,
    output logic adj_mode,
    output logic disp_hold
);

    localparam int unsigned CntW = deb_cnt_width(DEB_CYCLES);

    state_e state_q, state_d;
    logic   adj_s1_q, adj_s2_q;
    logic   sel_s1_q, sel_s2_q;
    logic   pause_ev;
    logic   count_en_q, count_en_d;
    logic   adj_step_q, adj_step_d;
    logic   adj_field_q, adj_field_d;

    btn_debounce #(
        .DebCycles (DEB_CYCLES),
        .CntW      (CntW)
    ) u_pause_deb (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (pause_btn),
        .press_o (pause_ev)
    );

    always_comb begin
        state_d     = state_q;
        count_en_d  = 1'b0;
        adj_step_d  = 1'b0;
        adj_field_d = adj_field_q;
        unique case (state_q)
            StClr:    state_d = StPaused;
            StPaused: begin
                if (adj_s2_q)      state_d = StAdj;
                else if (pause_ev) state_d = StRun;
            end
            StRun: begin
                if (adj_s2_q)      state_d = StAdj;
                else if (pause_ev) state_d = StPaused;
            end
            StAdj: begin
                if (!adj_s2_q)     state_d = StPaused;
            end
            default:               state_d = StClr;
        endcase
        // Pulses depend on the current state, so a tick on the RUN->PAUSED edge still counts.
        count_en_d = tick_1hz && (state_q == StRun);
        adj_step_d = tick_2hz && (state_q == StAdj);
        // Never retarget the field while a step pulse is being applied.
        if (!((state_q == StAdj) && adj_step_q)) begin
            adj_field_d = sel_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StClr;
            adj_s1_q    <= 1'b0;
            adj_s2_q    <= 1'b0;
            sel_s1_q    <= 1'b0;
            sel_s2_q    <= 1'b0;
            count_en_q  <= 1'b0;
            adj_step_q  <= 1'b0;
            adj_field_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            adj_s1_q    <= adj;
            adj_s2_q    <= adj_s1_q;
            sel_s1_q    <= sel;
            sel_s2_q    <= sel_s1_q;
            count_en_q  <= count_en_d;
            adj_step_q  <= adj_step_d;
            adj_field_q <= adj_field_d;
        end
    end

`ifdef WATCH_LAP_EN
    logic lap_ev;
    logic disp_hold_q, disp_hold_d;

    btn_debounce #(
        .DebCycles (DEB_CYCLES),
        .CntW      (CntW)
    ) u_lap_deb (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (lap_btn),
        .press_o (lap_ev)
    );

    always_comb begin
        disp_hold_d = disp_hold_q;
        if (state_d == StAdj) begin
            disp_hold_d = 1'b0;
        end else if (lap_ev && (state_q == StRun)) begin
            disp_hold_d = ~disp_hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_hold_q <= 1'b0;
        end else begin
            disp_hold_q <= disp_hold_d;
        end
    end

    assign disp_hold = disp_hold_q;
`else
    logic unused_lap_btn;
    assign unused_lap_btn = lap_btn;
    assign disp_hold      = 1'b0;
`endif

    assign cnt_clr   = (state_q == StClr);
    assign running   = (state_q == StRun);
    assign adj_mode  = (state_q == StAdj);
    assign count_en  = count_en_q;
    assign adj_step  = adj_step_q;
    assign adj_field = adj_field_q;

endmodule

// File: tb/tb_watch_sequencer.sv
// Directed self-checking bench for watch_sequencer with DEB_CYCLES = 4.
module tb_watch_sequencer;

    localparam int unsigned Deb = 4;
`ifdef WATCH_LAP_EN
    localparam logic LapEn = 1'b1;
`else
    localparam logic LapEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pause_btn = 1'b0, adj = 1'b0, sel = 1'b0;
    logic tick_1hz = 1'b0, tick_2hz = 1'b0, lap_btn = 1'b0;
    logic cnt_clr, count_en, adj_step, adj_field, running, adj_mode, disp_hold;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    watch_sequencer #(.DEB_CYCLES(Deb)) dut (
        .clk       (clk),
        .reset     (reset),
        .pause_btn (pause_btn),
        .adj       (adj),
        .sel       (sel),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .lap_btn   (lap_btn),
        .cnt_clr   (cnt_clr),
        .count_en  (count_en),
        .adj_step  (adj_step),
        .adj_field (adj_field),
        .running   (running),
        .adj_mode  (adj_mode),
        .disp_hold (disp_hold)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_pause();
        pause_btn = 1'b1; cyc(10);
        pause_btn = 1'b0; cyc(10);
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            outs = {count_en, adj_step, adj_field, running, adj_mode, disp_hold};
            n_checks++;
            if (cnt_clr !== 1'b1) begin
                n_fail++; $display("FAIL reset_cnt_clr[%0d]: got %b want 1", i, cnt_clr);
            end
            n_checks++;
            if (outs !== 6'b0) begin
                n_fail++; $display("FAIL reset_outputs[%0d]: got %b want 000000", i, outs);
            end
        end
        reset = 1'b0;
        n_checks++;
        if (cnt_clr !== 1'b1) begin
            n_fail++; $display("FAIL clr_extra_cycle: got %b want 1", cnt_clr);
        end
        cyc(1);
        outs = {count_en, adj_step, cnt_clr, running, adj_mode, disp_hold};
        n_checks++;
        if (outs !== 6'b0) begin
            n_fail++; $display("FAIL paused_after_clr: got %b want 000000", outs);
        end
    endtask

    task automatic test_run();
        int n = 0;
        bit found = 0;
        pause_btn = 1'b1;
        for (int i = 1; i <= 12 && !found; i++) begin
            cyc(1);
            if (running === 1'b1) begin
                found = 1; n = i;
            end
        end
        n_checks++;
        if (!found || n < 6 || n > 8) begin
            n_fail++; $display("FAIL run_latency: got %0d cycles (found=%0d) want 7+-1", n, found);
        end
        if (found) cyc(10 - n);
        pause_btn = 1'b0;
        cyc(10);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++; $display("FAIL release_no_event: running got %b want 1", running);
        end
        for (int k = 0; k < 3; k++) begin
            tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
            n_checks++;
            if (count_en !== 1'b1) begin
                n_fail++; $display("FAIL count_en_pulse[%0d]: got %b want 1", k, count_en);
            end
            cyc(1);
            n_checks++;
            if (count_en !== 1'b0) begin
                n_fail++; $display("FAIL count_en_width[%0d]: got %b want 0", k, count_en);
            end
            cyc(2);
        end
    endtask

    task automatic test_bounce();
        bit changed = 0;
        for (int i = 0; i < 10; i++) begin
            pause_btn = ~pause_btn;
            cyc(2);
            if (running !== 1'b1) changed = 1;
        end
        pause_btn = 1'b0;
        cyc(8);
        n_checks++;
        if (changed || running !== 1'b1) begin
            n_fail++; $display("FAIL bounce: changed=%0d running=%b want 0/1", changed, running);
        end
    endtask

    task automatic test_adj_priority();
        sel = 1'b1;
        pause_btn = 1'b1;
        cyc(4);
        adj = 1'b1;
        cyc(3);
        n_checks++;
        if ({adj_mode, running} !== 2'b10) begin
            n_fail++; $display("FAIL adj_priority: adj_mode,running got %b want 10", {adj_mode, running});
        end
        n_checks++;
        if (adj_field !== 1'b1) begin
            n_fail++; $display("FAIL adj_field_sync: got %b want 1", adj_field);
        end
        cyc(3);
        pause_btn = 1'b0;
        cyc(10);
        for (int k = 0; k < 2; k++) begin
            tick_2hz = 1'b1; tick_1hz = (k == 0); cyc(1);
            tick_2hz = 1'b0; tick_1hz = 1'b0;
            n_checks++;
            if ({adj_step, adj_field, count_en} !== 3'b110) begin
                n_fail++;
                $display("FAIL adj_step[%0d]: step,field,count_en got %b want 110", k,
                         {adj_step, adj_field, count_en});
            end
            cyc(1);
            n_checks++;
            if (adj_step !== 1'b0) begin
                n_fail++; $display("FAIL adj_step_width[%0d]: got %b want 0", k, adj_step);
            end
            cyc(2);
        end
        press_pause();
        n_checks++;
        if ({adj_mode, running} !== 2'b10) begin
            n_fail++; $display("FAIL adj_pause_discard: got %b want 10", {adj_mode, running});
        end
        adj = 1'b0;
        cyc(2);
        n_checks++;
        if (adj_mode !== 1'b1) begin
            n_fail++; $display("FAIL adj_exit_early: adj_mode got %b want 1", adj_mode);
        end
        cyc(1);
        n_checks++;
        if ({adj_mode, running, cnt_clr} !== 3'b000) begin
            n_fail++; $display("FAIL adj_exit_paused: got %b want 000", {adj_mode, running, cnt_clr});
        end
        sel = 1'b0;
    endtask

    task automatic test_pause_tick();
        press_pause();
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++; $display("FAIL resume_run: running got %b want 1", running);
        end
        pause_btn = 1'b1;
        cyc(6);
        tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
        n_checks++;
        if ({running, count_en} !== 2'b01) begin
            n_fail++; $display("FAIL pause_tick: running,count_en got %b want 01", {running, count_en});
        end
        cyc(1);
        n_checks++;
        if (count_en !== 1'b0) begin
            n_fail++; $display("FAIL pause_tick_width: got %b want 0", count_en);
        end
        cyc(2);
        pause_btn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
            n_checks++;
            if (count_en !== 1'b0) begin
                n_fail++; $display("FAIL paused_no_count[%0d]: got %b want 0", k, count_en);
            end
            cyc(1);
        end
        cyc(8);
    endtask

    task automatic test_lap();
        press_pause();
        lap_btn = 1'b1; cyc(8);
        n_checks++;
        if (disp_hold !== LapEn) begin
            n_fail++; $display("FAIL lap_toggle_on: got %b want %b", disp_hold, LapEn);
        end
        tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
        n_checks++;
        if (count_en !== 1'b1) begin
            n_fail++; $display("FAIL lap_count_continues: got %b want 1", count_en);
        end
        lap_btn = 1'b0; cyc(10);
        adj = 1'b1; cyc(3);
        n_checks++;
        if ({adj_mode, disp_hold} !== 2'b10) begin
            n_fail++; $display("FAIL lap_clear_on_adj: got %b want 10", {adj_mode, disp_hold});
        end
        adj = 1'b0; cyc(3);
        press_pause();
        lap_btn = 1'b1; cyc(10); lap_btn = 1'b0; cyc(10);
        n_checks++;
        if (disp_hold !== LapEn) begin
            n_fail++; $display("FAIL lap_toggle_again: got %b want %b", disp_hold, LapEn);
        end
        lap_btn = 1'b1; cyc(10); lap_btn = 1'b0; cyc(10);
        n_checks++;
        if ({running, disp_hold} !== 2'b10) begin
            n_fail++; $display("FAIL lap_toggle_off: running,hold got %b want 10", {running, disp_hold});
        end
    endtask

    task automatic test_reset_mid();
        pause_btn = 1'b1; cyc(3);
        reset = 1'b1; pause_btn = 1'b0; cyc(1);
        n_checks++;
        if ({cnt_clr, running, disp_hold, count_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mid: clr,run,hold,cnt got %b want 1000",
                     {cnt_clr, running, disp_hold, count_en});
        end
        reset = 1'b0; cyc(11);
        n_checks++;
        if ({cnt_clr, running, adj_mode} !== 3'b000) begin
            n_fail++; $display("FAIL reset_press_lost: got %b want 000", {cnt_clr, running, adj_mode});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run();
        test_bounce();
        test_adj_priority();
        test_pause_tick();
        test_lap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
